// File: rtl/mmio_pkg.sv
// Shared MMIO address map for the data-memory bus (print and input peripherals).
// Imported by the memory controller and by mmio_input_reader.
package mmio_pkg;

    localparam int          MMIO_DATA_W      = 32;
    localparam logic [31:0] PRINT_ADR        = 32'h8000_0064;
    localparam logic [31:0] INPUT_STATUS_ADR = 32'h8000_0068;
    localparam logic [31:0] INPUT_SWITCH_ADR = 32'h8000_006C;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_STATUS,
        SEL_SWITCH
    } rd_sel_e;

    // Full 32-bit compare; the switch register sits one word above the status register.
    function automatic rd_sel_e decode_rd(input logic ren, input logic [31:0] adr,
                                          input logic [31:0] base);
        rd_sel_e sel;
        sel = SEL_NONE;
        if (ren && adr == base)
            sel = SEL_STATUS;
        else if (ren && adr == base + 32'd4)
            sel = SEL_SWITCH;
        return sel;
    endfunction

endpackage

// File: rtl/debounce_cell.sv
// One input channel: 2-FF synchronizer followed by a saturating stability counter.
// The stable level only changes after DEBOUNCE_CYCLES consecutive differing synced samples.
module debounce_cell #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable
);

    localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             stable_reg;
    logic             stable_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_reg  <= 1'b0;
            sync2_reg  <= 1'b0;
            stable_reg <= 1'b0;
            cnt_reg    <= '0;
        end else begin
            sync1_reg  <= raw;
            sync2_reg  <= sync1_reg;
            stable_reg <= stable_next;
            cnt_reg    <= cnt_next;
        end
    end

    // Any sample agreeing with the stable level restarts the count, so glitches never accumulate.
    always_comb begin
        cnt_next    = cnt_reg;
        stable_next = stable_reg;
        if (sync2_reg == stable_reg) begin
            cnt_next = '0;
        end else if (cnt_reg == CNT_MAX) begin
            stable_next = sync2_reg;
            cnt_next    = '0;
        end else begin
            cnt_next = cnt_reg + 1'b1;
        end
    end

    assign stable = stable_reg;

endmodule

// File: rtl/mmio_input_reader.sv
// CPU-readable switch/button peripheral: debounced levels, sticky press events, 1-cycle load response.
// Optional MMIO_INPUT_IRQ_EN adds a registered irq output equal to the OR of pending events.
module mmio_input_reader
    import mmio_pkg::*;
#(
    parameter int          NUM_SW          = 16,
    parameter int          NUM_BTN         = 4,
    parameter int          DEBOUNCE_CYCLES = 500000,
    parameter logic [31:0] BASE_ADR        = INPUT_STATUS_ADR
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            MemoryAdr,
    input  logic                   ren,
    input  logic [NUM_SW-1:0]      sw_in,
    input  logic [NUM_BTN-1:0]     btn_in,
    output logic [MMIO_DATA_W-1:0] RdData,
    output logic                   RdValid
`ifdef MMIO_INPUT_IRQ_EN
    ,
    output logic                   irq
`endif
);

    logic [NUM_SW-1:0]      sw_stable;
    logic [NUM_BTN-1:0]     btn_stable;
    logic [NUM_BTN-1:0]     btn_prev_reg;
    logic [NUM_BTN-1:0]     btn_rise;
    logic [NUM_BTN-1:0]     evt_reg;
    logic [NUM_BTN-1:0]     evt_next;
    logic [NUM_BTN-1:0]     evt_clear;
    logic [MMIO_DATA_W-1:0] rd_data_reg;
    logic [MMIO_DATA_W-1:0] rd_data_next;
    logic                   rd_valid_reg;
    logic                   rd_valid_next;
    rd_sel_e                rd_sel;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_SW; gi++) begin : g_sw
            debounce_cell #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_db (
                .clk   (clk),
                .rst   (rst),
                .raw   (sw_in[gi]),
                .stable(sw_stable[gi])
            );
        end
        for (gi = 0; gi < NUM_BTN; gi++) begin : g_btn
            debounce_cell #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_db (
                .clk   (clk),
                .rst   (rst),
                .raw   (btn_in[gi]),
                .stable(btn_stable[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_prev_reg <= '0;
            evt_reg      <= '0;
            rd_data_reg  <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            btn_prev_reg <= btn_stable;
            evt_reg      <= evt_next;
            rd_data_reg  <= rd_data_next;
            rd_valid_reg <= rd_valid_next;
        end
    end

    // A new press in the clearing cycle is OR'd in after the clear, so it survives to the next read.
    always_comb begin
        rd_sel        = decode_rd(ren, MemoryAdr, BASE_ADR);
        btn_rise      = btn_stable & ~btn_prev_reg;
        evt_clear     = (rd_sel == SEL_STATUS) ? evt_reg : '0;
        evt_next      = (evt_reg & ~evt_clear) | btn_rise;
        rd_data_next  = '0;
        rd_valid_next = 1'b0;
        case (rd_sel)
            SEL_STATUS: begin
                rd_data_next[NUM_BTN-1:0] = evt_reg;
                rd_valid_next             = 1'b1;
            end
            SEL_SWITCH: begin
                rd_data_next[NUM_SW-1:0] = sw_stable;
                rd_valid_next            = 1'b1;
            end
            default: begin
                rd_data_next  = '0;
                rd_valid_next = 1'b0;
            end
        endcase
    end

    assign RdData  = rd_data_reg;
    assign RdValid = rd_valid_reg;

`ifdef MMIO_INPUT_IRQ_EN
    logic irq_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            irq_reg <= 1'b0;
        else
            irq_reg <= |evt_next;
    end

    assign irq = irq_reg;
`endif

endmodule

// File: tb/tb_mmio_input_reader.sv
// Scoreboard bench for mmio_input_reader: loads push expected responses, a negedge monitor checks them.
// Define MMIO_INPUT_IRQ_EN for both RTL and bench to exercise the irq output.
module tb_mmio_input_reader;

    localparam int NUM_SW  = 16;
    localparam int NUM_BTN = 4;
    localparam int DEB     = 4;

    localparam logic [31:0] ADR_PRINT  = 32'h8000_0064;
    localparam logic [31:0] ADR_STATUS = 32'h8000_0068;
    localparam logic [31:0] ADR_SWITCH = 32'h8000_006C;
    localparam logic [31:0] ADR_OTHER  = 32'h8000_0070;

    logic               clk = 1'b0;
    logic               rst;
    logic [31:0]        MemoryAdr;
    logic               ren;
    logic [NUM_SW-1:0]  sw_in;
    logic [NUM_BTN-1:0] btn_in;
    logic [31:0]        RdData;
    logic               RdValid;
`ifdef MMIO_INPUT_IRQ_EN
    logic               irq;
`endif

    always #5 clk = ~clk;

    mmio_input_reader #(
        .NUM_SW         (NUM_SW),
        .NUM_BTN        (NUM_BTN),
        .DEBOUNCE_CYCLES(DEB),
        .BASE_ADR       (ADR_STATUS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .MemoryAdr(MemoryAdr),
        .ren      (ren),
        .sw_in    (sw_in),
        .btn_in   (btn_in),
        .RdData   (RdData),
        .RdValid  (RdValid)
`ifdef MMIO_INPUT_IRQ_EN
        ,
        .irq      (irq)
`endif
    );

    typedef struct {
        logic        valid;
        logic [31:0] data;
        string       name;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    logic issued   = 1'b0;
    logic pend     = 1'b0;

    // A load presented before an edge has its response visible after that edge.
    always @(posedge clk) pend <= issued;

    always @(negedge clk) begin
        exp_t e;
        if (pend) begin
            n_checks++;
            if (q.size() == 0) begin
                $display("FAIL no_expectation: got valid=%0b data=%h", RdValid, RdData);
            end else begin
                e = q.pop_front();
                if (RdValid === e.valid && RdData === e.data) begin
                    n_pass++;
                    $display("ok   %s: valid=%0b data=%h", e.name, RdValid, RdData);
                end else begin
                    $display("FAIL %s: got valid=%0b data=%h, want valid=%0b data=%h",
                             e.name, RdValid, RdData, e.valid, e.data);
                end
            end
        end else if (!rst && RdValid !== 1'b0) begin
            n_checks++;
            $display("FAIL spurious_rdvalid: got valid=%0b data=%h, want valid=0", RdValid, RdData);
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) begin
            n_pass++;
            $display("ok   %s: %h", name, got);
        end else begin
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Called at a negedge; presents one load for one edge and queues the expected response.
    task automatic load(input string name, input logic r, input logic [31:0] adr,
                        input logic v, input logic [31:0] d);
        exp_t e;
        e.valid = v;
        e.data  = d;
        e.name  = name;
        q.push_back(e);
        ren       = r;
        MemoryAdr = adr;
        issued    = 1'b1;
        @(negedge clk);
        ren       = 1'b0;
        MemoryAdr = 32'h0;
        issued    = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        ren       = 1'b0;
        MemoryAdr = 32'h0;
        sw_in     = '0;
        btn_in    = '0;
        #2;
        check("reset_rddata", RdData, 32'h0);
        check("reset_rdvalid", {31'h0, RdValid}, 32'h0);
`ifdef MMIO_INPUT_IRQ_EN
        check("reset_irq", {31'h0, irq}, 32'h0);
`endif
        cyc(2);
        rst = 1'b0;

        sw_in = 16'hA5C3;
        cyc(10);
        load("switch_a5c3", 1'b1, ADR_SWITCH, 1'b1, 32'h0000_A5C3);

        // 3-cycle button glitch must not debounce; 8 cycles must.
        btn_in[0] = 1'b1;
        cyc(3);
        btn_in[0] = 1'b0;
        cyc(10);
        load("glitch_3cyc", 1'b1, ADR_STATUS, 1'b1, 32'h0);
        btn_in[0] = 1'b1;
        cyc(8);
        btn_in[0] = 1'b0;
        cyc(10);
        load("press_8cyc", 1'b1, ADR_STATUS, 1'b1, 32'h1);
        load("status_reread", 1'b1, ADR_STATUS, 1'b1, 32'h0);

        // btn[2]: sync at edges 1-2, count at 3-5, stable at 6, event set at 7 = load edge.
        btn_in[2] = 1'b1;
        cyc(6);
        load("collision_same_cycle", 1'b1, ADR_STATUS, 1'b1, 32'h0);
        load("collision_next", 1'b1, ADR_STATUS, 1'b1, 32'h4);

        btn_in[1] = 1'b1;
        cyc(10);
        load("decode_print_adr", 1'b1, ADR_PRINT, 1'b0, 32'h0);
        load("decode_adr_70", 1'b1, ADR_OTHER, 1'b0, 32'h0);
        load("decode_ren0", 1'b0, ADR_STATUS, 1'b0, 32'h0);
        load("decode_evt_intact", 1'b1, ADR_STATUS, 1'b1, 32'h2);

        sw_in = 16'h0F0F;
        cyc(10);
        load("switch_0f0f", 1'b1, ADR_SWITCH, 1'b1, 32'h0000_0F0F);

        // Reset while a response is on the bus and buttons 0/3 are mid-debounce.
        btn_in = 4'hF;
        cyc(3);
        ren       = 1'b1;
        MemoryAdr = ADR_SWITCH;
        @(posedge clk);
        #1;
        check("pre_reset_rdvalid", {31'h0, RdValid}, 32'h1);
        rst = 1'b1;
        #1;
        check("async_reset_rdvalid", {31'h0, RdValid}, 32'h0);
        check("async_reset_rddata", RdData, 32'h0);
`ifdef MMIO_INPUT_IRQ_EN
        check("async_reset_irq", {31'h0, irq}, 32'h0);
`endif
        ren       = 1'b0;
        MemoryAdr = 32'h0;
        @(negedge clk);
        cyc(2);
        rst = 1'b0;
        cyc(2);
        load("post_reset_early", 1'b1, ADR_STATUS, 1'b1, 32'h0);
        cyc(10);
        load("post_reset_held", 1'b1, ADR_STATUS, 1'b1, 32'hF);

        btn_in[3] = 1'b0;
        cyc(10);
        btn_in[3] = 1'b1;
        cyc(10);
`ifdef MMIO_INPUT_IRQ_EN
        check("irq_pending", {31'h0, irq}, 32'h1);
`endif
        load("btn3_status", 1'b1, ADR_STATUS, 1'b1, 32'h8);
`ifdef MMIO_INPUT_IRQ_EN
        check("irq_cleared", {31'h0, irq}, 32'h0);
`endif

        cyc(3);
        check("scoreboard_drained", q.size(), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
